// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter and sequencer for the shared 32-bit ALU.
// Two requesters, CPU core on port 0 and the recognition accelerator on port 1,
// compete for one combinational ALU. The winning operands are registered and held
// for a per-op number of cycles so that MUL and DIV can be constrained as
// multicycle paths. The ALU outputs are then captured and returned to the owner
// with a one-cycle response pulse.

module alu_share_arbiter #(
   parameter int unsigned MUL_LAT = 2,   // hold cycles for MUL (1..15)
   parameter int unsigned DIV_LAT = 4    // hold cycles for DIV (1..15)
) (
   input  logic        clk,
   input  logic        rst,
   // port 0: CPU core
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_x,
   input  logic [31:0] req0_y,
   // port 1: recognition accelerator
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_x,
   input  logic [31:0] req1_y,
   // responses (data shared, qualified by the per-port pulse)
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp_result,
   output logic [31:0] rsp_result2,
   output logic [2:0]  rsp_flags,
   // registered drive into the shared ALU and its outputs
   output logic [3:0]  alu_op,
   output logic [31:0] alu_x,
   output logic [31:0] alu_y,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_result2,
   input  logic        alu_equal,
   input  logic        alu_less,
   input  logic        alu_notless,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_r;
   logic        owner_r;
   logic        last_grant_r;
   logic [3:0]  cnt_r;
   logic [3:0]  alu_op_r;
   logic [31:0] alu_x_r;
   logic [31:0] alu_y_r;
   logic [31:0] rsp_result_r;
   logic [31:0] rsp_result2_r;
   logic [2:0]  rsp_flags_r;
   logic        rsp0_valid_r;
   logic        rsp1_valid_r;
   logic        busy_r;

   logic        grant_valid_s;
   logic        grant_s;
   logic        issue_s;
   logic [3:0]  sel_op_s;
   logic [31:0] sel_x_s;
   logic [31:0] sel_y_s;
   logic [3:0]  sel_cnt_s;

   // Number of cycles the ALU inputs must stay stable before the capture.
   function automatic logic [3:0] op_latency(input logic [3:0] op);
      logic [3:0] lat;
      case (op)
         4'd3:    lat = 4'(MUL_LAT);
         4'd4:    lat = 4'(DIV_LAT);
         default: lat = 4'd1;
      endcase
      return lat;
   endfunction

   // Round-robin choice: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_valid_s = 1'b1;
         grant_s       = ~last_grant_r;
      end else if (req0_valid) begin
         grant_valid_s = 1'b1;
         grant_s       = 1'b0;
      end else if (req1_valid) begin
         grant_valid_s = 1'b1;
         grant_s       = 1'b1;
      end else begin
         grant_valid_s = 1'b0;
         grant_s       = 1'b0;
      end
   end

   // Handshake strobe: only while idle and not being reset.
   always_comb begin
      issue_s    = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst && (state_r == IDLE) && grant_valid_s) begin
         issue_s    = 1'b1;
         req0_ready = ~grant_s;
         req1_ready = grant_s;
      end else begin
         issue_s    = 1'b0;
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end
   end

   // Operand mux for the granted port and its initial hold count.
   always_comb begin
      sel_op_s = 4'd0;
      sel_x_s  = 32'd0;
      sel_y_s  = 32'd0;
      if (grant_s) begin
         sel_op_s = req1_op;
         sel_x_s  = req1_x;
         sel_y_s  = req1_y;
      end else begin
         sel_op_s = req0_op;
         sel_x_s  = req0_x;
         sel_y_s  = req0_y;
      end
      sel_cnt_s = op_latency(sel_op_s) - 4'd1;
   end

   // Sequencer: accept, hold the ALU inputs for the op latency, capture, respond.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         owner_r       <= 1'b0;
         last_grant_r  <= 1'b1;
         cnt_r         <= 4'd0;
         alu_op_r      <= 4'd0;
         alu_x_r       <= 32'd0;
         alu_y_r       <= 32'd0;
         rsp_result_r  <= 32'd0;
         rsp_result2_r <= 32'd0;
         rsp_flags_r   <= 3'd0;
         rsp0_valid_r  <= 1'b0;
         rsp1_valid_r  <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (issue_s) begin
                  alu_op_r     <= sel_op_s;
                  alu_x_r      <= sel_x_s;
                  alu_y_r      <= sel_y_s;
                  owner_r      <= grant_s;
                  last_grant_r <= grant_s;
                  cnt_r        <= sel_cnt_s;
                  busy_r       <= 1'b1;
                  state_r      <= EXEC;
               end else begin
                  state_r <= IDLE;
               end
            end
            EXEC: begin
               if (cnt_r == 4'd0) begin
                  rsp_result_r  <= alu_result;
                  rsp_result2_r <= alu_result2;
                  rsp_flags_r   <= {alu_equal, alu_less, alu_notless};
                  rsp0_valid_r  <= ~owner_r;
                  rsp1_valid_r  <= owner_r;
                  state_r       <= RESP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               // No grant here: the earliest next handshake is the following IDLE cycle.
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign alu_op      = alu_op_r;
   assign alu_x       = alu_x_r;
   assign alu_y       = alu_y_r;
   assign rsp_result  = rsp_result_r;
   assign rsp_result2 = rsp_result2_r;
   assign rsp_flags   = rsp_flags_r;
   assign rsp0_valid  = rsp0_valid_r;
   assign rsp1_valid  = rsp1_valid_r;
   assign busy        = busy_r;

   alu_share_arbiter_chk u_chk (
      .clk        (clk),
      .rst        (rst),
      .state_idle (state_r == IDLE),
      .issue      (issue_s),
      .busy       (busy_r),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .rsp0_valid (rsp0_valid_r),
      .rsp1_valid (rsp1_valid_r),
      .alu_op     (alu_op_r),
      .alu_x      (alu_x_r),
      .alu_y      (alu_y_r)
   );

endmodule

// Invariants of the arbiter; holds no logic that drives the design.
module alu_share_arbiter_chk (
   input logic        clk,
   input logic        rst,
   input logic        state_idle,
   input logic        issue,
   input logic        busy,
   input logic        req0_ready,
   input logic        req1_ready,
   input logic        rsp0_valid,
   input logic        rsp1_valid,
   input logic [3:0]  alu_op,
   input logic [31:0] alu_x,
   input logic [31:0] alu_y
);

   a_rsp_onehot: assert property (@(posedge clk) disable iff (rst)
      !(rsp0_valid && rsp1_valid));

   a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
      !(req0_ready && req1_ready));

   a_ready_idle: assert property (@(posedge clk) disable iff (rst)
      (req0_ready || req1_ready) |-> state_idle);

   a_busy_state: assert property (@(posedge clk) disable iff (rst)
      busy == !state_idle);

   a_alu_hold: assert property (@(posedge clk) disable iff (rst)
      !issue |=> $stable({alu_op, alu_x, alu_y}));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized and directed stimulus for alu_share_arbiter.
// A behavioural ALU (which corrupts its outputs if the operands have not been held
// for the op latency) sits behind the DUT; a scoreboard queue holds the expected
// response of every accepted request and a negedge monitor checks it.

module tb_alu_share_arbiter;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv  [2];
   logic [3:0]  rop [2];
   logic [31:0] rx  [2];
   logic [31:0] ry  [2];
   logic        rdy0, rdy1;
   logic        rsp0_v, rsp1_v;
   logic [31:0] rsp_result, rsp_result2;
   logic [2:0]  rsp_flags;
   logic [3:0]  alu_op;
   logic [31:0] alu_x, alu_y;
   logic [31:0] alu_result, alu_result2;
   logic        alu_equal, alu_less, alu_notless;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   alu_share_arbiter #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(rv[0]), .req0_ready(rdy0), .req0_op(rop[0]), .req0_x(rx[0]), .req0_y(ry[0]),
      .req1_valid(rv[1]), .req1_ready(rdy1), .req1_op(rop[1]), .req1_x(rx[1]), .req1_y(ry[1]),
      .rsp0_valid(rsp0_v), .rsp1_valid(rsp1_v),
      .rsp_result(rsp_result), .rsp_result2(rsp_result2), .rsp_flags(rsp_flags),
      .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
      .alu_result(alu_result), .alu_result2(alu_result2),
      .alu_equal(alu_equal), .alu_less(alu_less), .alu_notless(alu_notless),
      .busy(busy)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference ALU ----------------
   function automatic int lat_of(input logic [3:0] op);
      if (op == 4'd3) return MUL_LAT;
      else if (op == 4'd4) return DIV_LAT;
      else return 1;
   endfunction

   // {result[66:35], result2[34:3], equal, less, notless}
   function automatic logic [66:0] alu_fn(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r, r2;
      logic [63:0] p;
      logic lt;
      r = 32'd0; r2 = 32'd0;
      case (op)
         4'd0:  r = x << y[4:0];
         4'd1:  r = 32'($signed(x) >>> y[4:0]);
         4'd2:  r = x >> y[4:0];
         4'd3:  begin p = longint'($signed(x)) * longint'($signed(y)); r = p[31:0]; r2 = p[63:32]; end
         4'd4:  if (y == 32'd0) begin r = 32'hFFFFFFFF; r2 = x; end
                else begin r = x / y; r2 = x % y; end
         4'd5:  r = x + y;
         4'd6:  r = x - y;
         4'd7:  r = x & y;
         4'd8:  r = x | y;
         4'd9:  r = x ^ y;
         4'd10: r = ~(x | y);
         4'd11: r = {31'd0, $signed(x) < $signed(y)};
         4'd12: r = {31'd0, x < y};
         default: r = 32'd0;
      endcase
      lt = (op == 4'd12) ? (x < y) : ($signed(x) < $signed(y));
      return {r, r2, x == y, lt, !lt};
   endfunction

   // cycles the ALU inputs have been unchanged, counting the current cycle
   int          held = 0;
   logic [3:0]  h_op;
   logic [31:0] h_x, h_y;
   always @(negedge clk) begin
      if (alu_op === h_op && alu_x === h_x && alu_y === h_y) held = (held < 15) ? held + 1 : 15;
      else held = 1;
      h_op = alu_op; h_x = alu_x; h_y = alu_y;
   end

   logic [66:0] alu_o;
   always_comb begin
      alu_o = alu_fn(alu_op, alu_x, alu_y);
      if (held < lat_of(alu_op)) alu_o[66:3] = alu_o[66:3] ^ {32'hDEADBEEF, 32'h5A5A5A5A};
   end
   assign alu_result  = alu_o[66:35];
   assign alu_result2 = alu_o[34:3];
   assign alu_equal   = alu_o[2];
   assign alu_less    = alu_o[1];
   assign alu_notless = alu_o[0];

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          port;
      int          due;
      logic [31:0] r;
      logic [31:0] r2;
      logic [2:0]  f;
   } exp_t;

   exp_t q[$];
   int   last_m    = 1;
   int   next_free = 0;
   int   hs_cyc [2];
   logic        pv   [2];
   logic        pacc [2];
   logic [3:0]  pop  [2];
   logic [31:0] px   [2];
   logic [31:0] py   [2];

   // Monitor: arbitration model, scoreboard push on handshake, pop on response.
   always @(negedge clk) begin
      int g;
      bit any, idle_m, rd;
      exp_t e;
      logic [66:0] o;
      any    = rv[0] || rv[1];
      idle_m = (cyc >= next_free);
      if (rv[0] && rv[1]) g = (last_m == 0) ? 1 : 0;
      else if (rv[0]) g = 0;
      else g = 1;
      if (!rst) check("busy", busy, !idle_m);
      check("ready0", rdy0, !rst && idle_m && any && g == 0);
      check("ready1", rdy1, !rst && idle_m && any && g == 1);
      for (int p = 0; p < 2; p++) begin
         rd = (p == 0) ? rdy0 : rdy1;
         if (pv[p] && !pacc[p] && rv[p] && {rop[p], rx[p], ry[p]} != {pop[p], px[p], py[p]}) begin
            n_err++;
            $display("FAIL req_stable port %0d: request changed while waiting, got op %0d, required op %0d", p, rop[p], pop[p]);
         end
         pv[p] = rv[p]; pacc[p] = rv[p] && rd; pop[p] = rop[p]; px[p] = rx[p]; py[p] = ry[p];
         if (rv[p] && rd) begin
            o      = alu_fn(rop[p], rx[p], ry[p]);
            e.port = p;
            e.due  = cyc + lat_of(rop[p]) + 1;
            e.r    = o[66:35];
            e.r2   = o[34:3];
            e.f    = o[2:0];
            q.push_back(e);
            last_m    = p;
            next_free = cyc + lat_of(rop[p]) + 2;
            hs_cyc[p] = cyc;
         end
      end
      if (rsp0_v || rsp1_v) begin
         check("rsp_onehot", rsp0_v && rsp1_v, 1'b0);
         check("rsp_expected", q.size() != 0, 1'b1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("rsp_port", rsp1_v, e.port);
            check("rsp_cycle", cyc, e.due);
            check("rsp_result", rsp_result, e.r);
            check("rsp_result2", rsp_result2, e.r2);
            check("rsp_flags", rsp_flags, e.f);
         end
      end
      if (rst) begin
         q.delete();
         last_m    = 1;
         next_free = cyc + 1;
      end
   end

   // ---------------- stimulus ----------------
   // Called just after a rising edge; holds the request until accepted.
   task automatic send(input int p, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      int  n;
      bit  got;
      rop[p] = op; rx[p] = x; ry[p] = y; rv[p] = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         got = (p == 0) ? rdy0 : rdy1;
         n++;
      end
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout port %0d: ready got 0 for 200 cycles, required 1", p);
      end
      @(posedge clk); #1;
      rv[p] = 1'b0;
   endtask

   // Waits for the next response pulse and checks it against fixed values.
   task automatic expect_rsp(input int p, input logic [31:0] r, input logic [31:0] r2,
                             input logic [2:0] f, input int lat);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(rsp0_v || rsp1_v) && n < 50);
      if (!(rsp0_v || rsp1_v)) begin
         n_vec++; n_err++;
         $display("FAIL dir_timeout port %0d: no response in 50 cycles, required one", p);
      end else begin
         check("dir_port", rsp1_v, p);
         check("dir_latency", cyc - hs_cyc[p], lat + 1);
         check("dir_result", rsp_result, r);
         check("dir_result2", rsp_result2, r2);
         check("dir_flags", rsp_flags, f);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int p = 0; p < 2; p++) begin
         rv[p] = 1'b0; rop[p] = 4'd0; rx[p] = 32'd0; ry[p] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_result", rsp_result, 32'd0);
      check("rst_alu", {alu_op, alu_x[27:0]}, 32'd0);
      check("rst_busy", {busy, rsp0_v, rsp1_v}, 3'd0);

      // tie from reset: port 0 first, port 1 three cycles later, then port 0 alone
      fork
         send(0, 4'd6, 32'd10, 32'd4);
         send(1, 4'd6, 32'd10, 32'd4);
         begin
            expect_rsp(0, 32'd6, 32'd0, 3'b001, 1);
            expect_rsp(1, 32'd6, 32'd0, 3'b001, 1);
         end
      join
      check("rr_spacing", hs_cyc[1] - hs_cyc[0], 3);
      send(0, 4'd6, 32'd10, 32'd4);
      expect_rsp(0, 32'd6, 32'd0, 3'b001, 1);

      // ADD and DIV
      send(0, 4'd5, 32'd3, 32'd4);
      expect_rsp(0, 32'd7, 32'd0, 3'b010, 1);
      send(1, 4'd4, 32'd17, 32'd5);
      expect_rsp(1, 32'd3, 32'd2, 3'b001, DIV_LAT);

      // signed vs unsigned compare
      send(0, 4'd11, 32'hFFFFFFFF, 32'd1);
      expect_rsp(0, 32'd1, 32'd0, 3'b010, 1);
      send(0, 4'd12, 32'hFFFFFFFF, 32'd1);
      expect_rsp(0, 32'd0, 32'd0, 3'b001, 1);

      // MUL interrupted by reset mid-EXEC: no response, everything cleared
      send(0, 4'd3, 32'h10000, 32'h10000);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("mid_rst_result", rsp_result, 32'd0);
      check("mid_rst_result2", rsp_result2, 32'd0);
      check("mid_rst_flags", rsp_flags, 3'd0);
      check("mid_rst_alu_x", alu_x, 32'd0);
      check("mid_rst_alu_y", alu_y, 32'd0);
      check("mid_rst_op_busy", {alu_op, busy, rsp0_v, rsp1_v}, 7'd0);
      repeat (6) @(posedge clk);
      #1;
      send(0, 4'd5, 32'd1, 32'd1);
      expect_rsp(0, 32'd2, 32'd0, 3'b101, 1);

      // randomized traffic on both ports
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               logic [31:0] x0;
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               x0 = $urandom;
               send(0, 4'($urandom_range(0, 15)), x0,
                    ($urandom_range(0, 3) == 0) ? x0 : 32'($urandom));
            end
         end
         begin
            for (int j = 0; j < 150; j++) begin
               logic [31:0] x1;
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               x1 = $urandom;
               send(1, 4'($urandom_range(0, 15)), x1,
                    ($urandom_range(0, 3) == 0) ? x1 : 32'($urandom_range(0, 40)));
            end
         end
      join
      repeat (20) @(posedge clk);
      #1;
      check("drain", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
